// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
// Declarations shared by the deserializer and anything that inspects it:
//   state_t   - FSM encoding (IDLE: waiting for a first bit, COLLECT: mid-word)
//   MIN_BURST - shortest burst accepted when the short-burst error feature
//               (DESERIALIZER_SHORT_ERR_EN) is compiled in
// -----------------------------------------------------------------------------
package deserializer_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam int MIN_BURST = 3;

endpackage : deserializer_pkg

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Rebuilds parallel words from an MSB-first serial stream. A word closes when
// DATA_W bits have been collected (emitted one cycle after the last bit) or
// when the valid strobe drops mid-word (partial word emitted two cycles after
// the last bit). Output words are left-aligned with unreceived LSBs zero.
//
// Optional feature (macro DESERIALIZER_SHORT_ERR_EN): bursts shorter than
// MIN_BURST bits are dropped and flagged on short_err_o instead of emitted.
//
// Ports:
//   clk_i            in   clock, rising edge
//   srst_i           in   synchronous active-high reset
//   ser_data_i       in   serial bit, MSB first
//   ser_data_val_i   in   ser_data_i valid this cycle
//   deser_data_o     out  [DATA_W] reconstructed word, left-aligned
//   deser_data_mod_o out  [MOD_W]  bits received, 0 means DATA_W
//   deser_data_val_o out  one-cycle pulse, data/mod valid
//   busy_o           out  high while a word is partially collected
//   short_err_o      out  short-burst pulse (only with the feature macro)
// -----------------------------------------------------------------------------
module deserializer
   import deserializer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              ser_data_i,
   input  logic              ser_data_val_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic [MOD_W-1:0]  deser_data_mod_o,
   output logic              deser_data_val_o,
   output logic              busy_o
`ifdef DESERIALIZER_SHORT_ERR_EN
   ,
   output logic              short_err_o
`endif
);

   // One extra bit so the count can represent DATA_W itself.
   localparam int CNT_W = MOD_W + 1;
   localparam logic [MOD_W-1:0] TOP_IDX = MOD_W'(DATA_W - 1);

   state_t              r_state,  w_state_next;
   logic [CNT_W-1:0]    r_count,  w_count_next;
   logic [DATA_W-1:0]   r_shift,  w_shift_next;
   logic [DATA_W-1:0]   r_data,   w_data_next;
   logic [MOD_W-1:0]    r_mod,    w_mod_next;
   logic                r_val,    w_val_next;
   logic [MOD_W-1:0]    w_idx;
   logic [DATA_W-1:0]   w_word;

`ifdef DESERIALIZER_SHORT_ERR_EN
   logic                r_short_err, w_short_err_next;
`endif

   // Bit position for the incoming bit: MSB first, so index falls as count rises.
   assign w_idx = TOP_IDX - r_count[MOD_W-1:0];

   // Shift register with the current bit merged in; this is the completed word
   // on the cycle the final bit arrives.
   always_comb begin
      w_word        = r_shift;
      w_word[w_idx] = ser_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_mod       <= '0;
         r_val       <= 1'b0;
`ifdef DESERIALIZER_SHORT_ERR_EN
         r_short_err <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_count     <= w_count_next;
         r_shift     <= w_shift_next;
         r_data      <= w_data_next;
         r_mod       <= w_mod_next;
         r_val       <= w_val_next;
`ifdef DESERIALIZER_SHORT_ERR_EN
         r_short_err <= w_short_err_next;
`endif
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_count_next     = r_count;
      w_shift_next     = r_shift;
      w_data_next      = r_data;
      w_mod_next       = r_mod;
      w_val_next       = 1'b0;
`ifdef DESERIALIZER_SHORT_ERR_EN
      w_short_err_next = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (ser_data_val_i) begin
               w_shift_next             = '0;
               w_shift_next[DATA_W-1]   = ser_data_i;
               w_count_next             = CNT_W'(1);
               w_state_next             = COLLECT;
            end
         end
         COLLECT: begin
            if (ser_data_val_i) begin
               if (r_count == CNT_W'(DATA_W - 1)) begin
                  // Last bit: publish now so a new word may start next cycle.
                  w_data_next  = w_word;
                  w_mod_next   = '0;
                  w_val_next   = 1'b1;
                  w_shift_next = '0;
                  w_count_next = '0;
                  w_state_next = IDLE;
               end else begin
                  w_shift_next = w_word;
                  w_count_next = r_count + CNT_W'(1);
               end
            end else begin
               // Valid dropped mid-word: close out the partial word.
`ifdef DESERIALIZER_SHORT_ERR_EN
               if (r_count < CNT_W'(MIN_BURST)) begin
                  w_short_err_next = 1'b1;
               end else begin
                  w_data_next = r_shift;
                  w_mod_next  = r_count[MOD_W-1:0];
                  w_val_next  = 1'b1;
               end
`else
               w_data_next  = r_shift;
               w_mod_next   = r_count[MOD_W-1:0];
               w_val_next   = 1'b1;
`endif
               w_shift_next = '0;
               w_count_next = '0;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_count_next = '0;
            w_shift_next = '0;
         end
      endcase
   end

   assign deser_data_o     = r_data;
   assign deser_data_mod_o = r_mod;
   assign deser_data_val_o = r_val;
   assign busy_o           = (r_state == COLLECT);
`ifdef DESERIALIZER_SHORT_ERR_EN
   assign short_err_o      = r_short_err;
`endif

endmodule : deserializer

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
// Directed stimulus with hand-computed expected words; expectations are queued
// by the stimulus process and consumed by an independent monitor that samples
// DUT outputs on the falling edge. Build with +define+DESERIALIZER_SHORT_ERR_EN
// to exercise the short-burst error variant.
// -----------------------------------------------------------------------------
module tb_deserializer;

   localparam int DATA_W = 16;
   localparam int MOD_W  = 4;

   logic              clk = 1'b0;
   logic              srst_i;
   logic              ser_data_i;
   logic              ser_data_val_i;
   logic [DATA_W-1:0] deser_data_o;
   logic [MOD_W-1:0]  deser_data_mod_o;
   logic              deser_data_val_o;
   logic              busy_o;
`ifdef DESERIALIZER_SHORT_ERR_EN
   logic              short_err_o;
`endif

   deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
      .clk_i            (clk),
      .srst_i           (srst_i),
      .ser_data_i       (ser_data_i),
      .ser_data_val_i   (ser_data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_data_mod_o (deser_data_mod_o),
      .deser_data_val_o (deser_data_val_o),
      .busy_o           (busy_o)
`ifdef DESERIALIZER_SHORT_ERR_EN
      ,
      .short_err_o      (short_err_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [MOD_W-1:0]  mod;
      int                at;
   } exp_t;

   exp_t exp_q[$];
   int   short_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [DATA_W-1:0] last_data = '0;
   logic [MOD_W-1:0]  last_mod  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   exp_t e;
   int   s_at;
   always @(negedge clk) begin
      if (deser_data_val_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got data %0h mod %0d at cycle %0d, expected none",
                     deser_data_o, deser_data_mod_o, cyc);
         end else begin
            e = exp_q.pop_front();
            $display("pulse: data=%04h mod=%0d cycle=%0d (expected %04h/%0d/%0d)",
                     deser_data_o, deser_data_mod_o, cyc, e.data, e.mod, e.at);
            check("pulse_data",  32'(deser_data_o),     32'(e.data));
            check("pulse_mod",   32'(deser_data_mod_o), 32'(e.mod));
            check("pulse_cycle", 32'(cyc),              32'(e.at));
         end
      end
`ifdef DESERIALIZER_SHORT_ERR_EN
      if (short_err_o === 1'b1) begin
         if (short_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_short_err: got pulse at cycle %0d, expected none", cyc);
         end else begin
            s_at = short_q.pop_front();
            $display("short_err: cycle=%0d (expected %0d)", cyc, s_at);
            check("short_err_cycle", 32'(cyc), 32'(s_at));
         end
      end
`endif
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      ser_data_val_i = 1'b0;
      ser_data_i     = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends the top nbits of w MSB first and queues the expected result.
   // w must already be left-aligned with zeros below the sent bits.
   task automatic send_word(input logic [DATA_W-1:0] w, input int nbits, input bit expect_out);
      int   c;
      exp_t x;
      c = 0;
      for (int i = 0; i < nbits; i++) begin
         if (i == nbits - 1 && nbits > 1) check("busy_mid_word", 32'(busy_o), 32'd1);
         ser_data_i     = w[DATA_W-1-i];
         ser_data_val_i = 1'b1;
         c = cyc;
         @(posedge clk);
         #1;
      end
      if (!expect_out) return;
`ifdef DESERIALIZER_SHORT_ERR_EN
      if (nbits < 3) begin
         short_q.push_back(c + 2);
         return;
      end
`endif
      x.data = w;
      x.mod  = MOD_W'(nbits);
      x.at   = (nbits == DATA_W) ? c + 1 : c + 2;
      exp_q.push_back(x);
      last_data = w;
      last_mod  = MOD_W'(nbits);
   endtask

   initial begin
      srst_i         = 1'b1;
      ser_data_i     = 1'b0;
      ser_data_val_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      srst_i = 1'b0;
      check("reset_data",  32'(deser_data_o),     32'd0);
      check("reset_mod",   32'(deser_data_mod_o), 32'd0);
      check("reset_val",   32'(deser_data_val_o), 32'd0);
      check("reset_busy",  32'(busy_o),           32'd0);
`ifdef DESERIALIZER_SHORT_ERR_EN
      check("reset_short", 32'(short_err_o),      32'd0);
`endif
      idle(2);

      // Full word
      send_word(16'hA5C3, 16, 1'b1);
      idle(3);
      check("busy_after_full", 32'(busy_o), 32'd0);

      // Partial burst 1,0,1,1,0
      send_word(16'hB000, 5, 1'b1);
      idle(3);

      // Back-to-back full words, no gap
      send_word(16'hFFFF, 16, 1'b1);
      send_word(16'h0001, 16, 1'b1);
      idle(3);

      // Reset mid-word: 7-bit fragment must vanish
      send_word(16'h5A00, 7, 1'b0);
      ser_data_val_i = 1'b0;
      srst_i         = 1'b1;
      @(posedge clk);
      #1;
      srst_i = 1'b0;
      last_data = '0;
      last_mod  = '0;
      check("busy_after_reset", 32'(busy_o),       32'd0);
      check("data_after_reset", 32'(deser_data_o), 32'd0);
      send_word(16'h1234, 16, 1'b1);
      idle(3);

      // Short burst of two bits
      send_word(16'hC000, 2, 1'b1);
      idle(3);

      // Idle hold
      for (int i = 0; i < 20; i++) begin
         check("hold_val", 32'(deser_data_val_o), 32'd0);
         idle(1);
      end
      check("hold_data", 32'(deser_data_o),     32'(last_data));
      check("hold_mod",  32'(deser_data_mod_o), 32'(last_mod));
      check("hold_busy", 32'(busy_o),           32'd0);

      check("pending_pulses", 32'(exp_q.size()),   32'd0);
      check("pending_short",  32'(short_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_deserializer
